// File: rtl/conv_drain_pkg.sv
// Shared types and helpers for the conv_layer result read-out stage.
package conv_drain_pkg;

    localparam int unsigned SIG_WIDTH = 32;

    typedef enum logic [1:0] {IDLE, READ, FLUSH, DONE} drain_state_t;

    // One signature step: rotate left by one, then fold in the XOR of the word's 32-bit slices.
    function automatic logic [SIG_WIDTH-1:0] sig_fold(input logic [SIG_WIDTH-1:0] sig,
                                                      input logic [SIG_WIDTH-1:0] slice_xor);
        return {sig[SIG_WIDTH-2:0], sig[SIG_WIDTH-1]} ^ slice_xor;
    endfunction

endpackage

// File: rtl/drain_skid_fifo.sv
// Two-entry synchronous FIFO; push while full is accepted only together with a pop.
module drain_skid_fifo #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] mem_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       cnt_q;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (cnt_q != 2'd0);
    assign do_push = push && ((cnt_q != 2'd2) || do_pop);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            cnt_q <= cnt_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    assign full  = (cnt_q == 2'd2);
    assign empty = (cnt_q == 2'd0);
    assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/conv_result_drain.sv
// Sweeps an address window of one conv_layer result BRAM, streams the words out
// on valid/ready and folds each delivered word into a running signature.
module conv_result_drain #(
    parameter int unsigned DWIDTH       = 16,
    parameter int unsigned MAT_MUL_SIZE = 4,
    parameter int unsigned AWIDTH       = 10,
    parameter int unsigned SIG_WIDTH    = conv_drain_pkg::SIG_WIDTH
) (
    input  logic                           clk,
    input  logic                           resetn,
    input  logic                           start,
    input  logic [7:0]                     cfg_select,
    input  logic [AWIDTH-1:0]              cfg_base,
    input  logic [AWIDTH:0]                cfg_count,
    output logic [7:0]                     bram_select,
    output logic [AWIDTH-1:0]              bram_addr_ext,
    output logic [MAT_MUL_SIZE-1:0]        bram_we_ext,
    input  logic [MAT_MUL_SIZE*DWIDTH-1:0] bram_rdata_ext,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [MAT_MUL_SIZE*DWIDTH-1:0] out_data,
    output logic [SIG_WIDTH-1:0]           signature,
    output logic                           busy,
    output logic                           drain_done
);

    import conv_drain_pkg::*;

    localparam int unsigned WWIDTH = MAT_MUL_SIZE * DWIDTH;
    localparam int unsigned NSLICE = WWIDTH / 32;

    drain_state_t          state_q;
    logic [7:0]            sel_q;
    logic [AWIDTH-1:0]     base_q;
    logic [AWIDTH-1:0]     last_addr_q;
    logic [AWIDTH:0]       count_q;
    logic [AWIDTH:0]       issued_q;
    logic                  inflight_q;
    logic [SIG_WIDTH-1:0]  sig_q;

    logic                  fifo_full;
    logic                  fifo_empty;
    logic [WWIDTH-1:0]     head;
    logic                  pop;
    logic                  issue;
    logic [1:0]            occ;
    logic [1:0]            load;
    logic [AWIDTH-1:0]     issue_addr;
    logic [31:0]           word_fold;

    assign pop = !fifo_empty && out_ready;

    // Credit counts occupancy net of this cycle's pop so a steady stream keeps 1 word/cycle.
    always_comb begin
        occ        = fifo_full ? 2'd2 : (fifo_empty ? 2'd0 : 2'd1);
        load       = occ + {1'b0, inflight_q} - {1'b0, pop};
        issue      = (state_q == READ) && (load < 2'd2);
        issue_addr = base_q + issued_q[AWIDTH-1:0];
    end

    always_comb begin
        word_fold = '0;
        for (int unsigned i = 0; i < NSLICE; i++) begin
            word_fold = word_fold ^ head[i*32 +: 32];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            base_q      <= '0;
            last_addr_q <= '0;
            count_q     <= '0;
            issued_q    <= '0;
            inflight_q  <= 1'b0;
            sig_q       <= '0;
        end else begin
            inflight_q <= issue;
            if (issue) begin
                last_addr_q <= issue_addr;
                issued_q    <= issued_q + 1'b1;
            end
            if (pop) begin
                sig_q <= sig_fold(sig_q, word_fold);
            end
            unique case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        sel_q    <= cfg_select;
                        base_q   <= cfg_base;
                        count_q  <= cfg_count;
                        issued_q <= '0;
                        sig_q    <= '0;
                        state_q  <= (cfg_count == '0) ? DONE : READ;
                    end
                end
                READ: begin
                    if (issue && (issued_q + 1'b1 == count_q)) begin
                        state_q <= FLUSH;
                    end
                end
                FLUSH: begin
                    // Leave as soon as the last word is being popped, so DONE follows the final pop.
                    if (!inflight_q && (fifo_empty || (!fifo_full && pop))) begin
                        state_q <= DONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    drain_skid_fifo #(
        .WIDTH(WWIDTH)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (inflight_q),
        .pop    (pop),
        .wdata  (bram_rdata_ext),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .head   (head)
    );

    assign bram_select   = (state_q == IDLE) ? 8'd0 : sel_q;
    assign bram_addr_ext = issue ? issue_addr : last_addr_q;
    assign bram_we_ext   = '0;
    assign out_valid     = !fifo_empty;
    assign out_data      = head;
    assign signature     = sig_q;
    assign busy          = (state_q == READ) || (state_q == FLUSH);
    assign drain_done    = (state_q == DONE);

endmodule
